// File: rtl/uart_pkg.sv
// Shared definitions for the memory-mapped 8N1 UART: register map,
// STATUS bit positions and the state encoding used by both serial FSMs.
package uart_pkg;

  // Byte offsets inside the 8-byte register window.
  localparam logic [2:0] UART_DATA    = 3'd0;
  localparam logic [2:0] UART_STATUS  = 3'd2;
  localparam logic [2:0] UART_DIVISOR = 3'd4;
  localparam logic [2:0] UART_IE      = 3'd6;

  localparam int ST_TXIDLE  = 0;
  localparam int ST_TXFULL  = 1;
  localparam int ST_RXAVAIL = 2;
  localparam int ST_RXFULL  = 3;
  localparam int ST_FE      = 4;
  localparam int ST_RXOVR   = 5;
  localparam int ST_TXOVR   = 6;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_t;

  // Bit period in clocks; divisors below 2 would leave no room for a mid-bit sample.
  function automatic logic [15:0] eff_period(input logic [15:0] divisor);
    return (divisor < 16'd2) ? 16'd2 : divisor;
  endfunction

endpackage

// File: rtl/uart_fifo.sv
// 8-bit synchronous FIFO; pointers carry one extra wrap bit so full and
// empty are told apart by comparing the MSBs.
module uart_fifo #(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       push_i,
  input  logic [7:0] wdata_i,
  input  logic       pop_i,
  output logic [7:0] rdata_o,
  output logic       full_o,
  output logic       empty_o
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0] wr_ptr_q, rd_ptr_q;
  logic [7:0]  mem_q [DEPTH];
  logic        do_push, do_pop;

  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

  // A pop frees the slot this cycle, so a push into a full FIFO is accepted alongside it.
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  // NOTE: state updates use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  // NOTE: storage has no reset; the pointers alone define which entries are valid.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
  end

  assign rdata_o = mem_q[rd_ptr_q[AW-1:0]];

endmodule

// File: rtl/uart.sv
// Memory-mapped 8N1 UART: register window on the CPU data bus, TX/RX FIFOs,
// bit-period timing and the two serial FSMs, plus a level interrupt.
module uart
  import uart_pkg::*;
#(
  parameter logic [15:0] ADDRBASE        = 16'h0010,
  parameter int          TXDEPTH         = 4,
  parameter int          RXDEPTH         = 4,
  parameter logic [15:0] DEFAULT_DIVISOR = 16'd104
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] dread_addr,
  output logic [15:0] dread_data,
  input  logic [15:0] dwrite_addr,
  input  logic [15:0] dwrite_data,
  input  logic [1:0]  dwrite_en,
  input  logic        rxd,
  output logic        txd,
  output logic        interrupt
);

  logic        wr_hit, wr_push, wr_cmd, cpu_pop;
  logic [2:0]  wr_off, w1c;
  logic        unused_addr_lsb;

  assign wr_hit  = (dwrite_addr[15:3] == ADDRBASE[15:3]);
  assign wr_off  = {dwrite_addr[2:1], 1'b0};
  assign wr_push = wr_hit && (wr_off == UART_DATA) && dwrite_en[0];
  assign wr_cmd  = wr_hit && (wr_off == UART_STATUS) && dwrite_en[0];
  assign cpu_pop = wr_cmd && dwrite_data[0];
  assign w1c     = wr_cmd ? dwrite_data[6:4] : 3'b000;
  assign unused_addr_lsb = dread_addr[0] ^ dwrite_addr[0];

  // ---------------------------------------------------------------- FIFOs
  logic       tx_push, tx_pop, tx_full, tx_empty;
  logic       rx_push, rx_full, rx_empty;
  logic [7:0] tx_head, rx_head, rx_shift_q;

  assign tx_push = wr_push && !tx_full;

  uart_fifo #(.DEPTH(TXDEPTH)) u_tx_fifo (
    .clk     (clk),
    .rst_n   (reset),
    .push_i  (tx_push),
    .wdata_i (dwrite_data[7:0]),
    .pop_i   (tx_pop),
    .rdata_o (tx_head),
    .full_o  (tx_full),
    .empty_o (tx_empty)
  );

  uart_fifo #(.DEPTH(RXDEPTH)) u_rx_fifo (
    .clk     (clk),
    .rst_n   (reset),
    .push_i  (rx_push),
    .wdata_i (rx_shift_q),
    .pop_i   (cpu_pop),
    .rdata_o (rx_head),
    .full_o  (rx_full),
    .empty_o (rx_empty)
  );

  // ---------------------------------------------------------- registers
  logic [15:0] div_q, div_d, period;
  logic [2:0]  ie_q, ie_d;
  logic        fe_q, fe_d, rxovr_q, rxovr_d, txovr_q, txovr_d;
  logic        fe_set, rxovr_set, txovr_set;

  assign period = eff_period(div_q);

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    div_d = div_q;
    ie_d  = ie_q;
    if (wr_hit && wr_off == UART_DIVISOR) begin
      if (dwrite_en[0]) div_d[7:0]  = dwrite_data[7:0];
      if (dwrite_en[1]) div_d[15:8] = dwrite_data[15:8];
    end
    if (wr_hit && wr_off == UART_IE && dwrite_en[0]) ie_d = dwrite_data[2:0];
    // A fresh event in the same cycle as its clear keeps the flag set.
    fe_d    = (fe_q    & ~w1c[0]) | fe_set;
    rxovr_d = (rxovr_q & ~w1c[1]) | rxovr_set;
    txovr_d = (txovr_q & ~w1c[2]) | txovr_set;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      div_q   <= DEFAULT_DIVISOR;
      ie_q    <= '0;
      fe_q    <= 1'b0;
      rxovr_q <= 1'b0;
      txovr_q <= 1'b0;
    end else begin
      div_q   <= div_d;
      ie_q    <= ie_d;
      fe_q    <= fe_d;
      rxovr_q <= rxovr_d;
      txovr_q <= txovr_d;
    end
  end

  // ------------------------------------------------------------- TX FSM
  uart_state_t tx_state_q;
  logic [15:0] tx_cnt_q, tx_per_q;
  logic [2:0]  tx_bit_q;
  logic [7:0]  tx_shift_q;
  logic        txd_q, tx_tick;

  assign tx_tick   = (tx_cnt_q == '0);
  assign tx_pop    = tx_tick && !tx_empty && (tx_state_q == IDLE || tx_state_q == STOP);
  assign txovr_set = wr_push && tx_full;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tx_state_q <= IDLE;
      tx_cnt_q   <= '0;
      tx_per_q   <= 16'd2;
      tx_bit_q   <= '0;
      tx_shift_q <= '0;
      txd_q      <= 1'b1;
    end else if (!tx_tick) begin
      tx_cnt_q <= tx_cnt_q - 16'd1;
    end else begin
      unique case (tx_state_q)
        IDLE: ;
        START: begin
          tx_state_q <= DATA;
          tx_cnt_q   <= tx_per_q - 16'd1;
          tx_bit_q   <= '0;
          txd_q      <= tx_shift_q[0];
          tx_shift_q <= {1'b0, tx_shift_q[7:1]};
        end
        DATA: begin
          tx_cnt_q <= tx_per_q - 16'd1;
          if (tx_bit_q == 3'd7) begin
            tx_state_q <= STOP;
            txd_q      <= 1'b1;
          end else begin
            tx_bit_q   <= tx_bit_q + 3'd1;
            txd_q      <= tx_shift_q[0];
            tx_shift_q <= {1'b0, tx_shift_q[7:1]};
          end
        end
        STOP: tx_state_q <= IDLE;
        default: tx_state_q <= IDLE;
      endcase
      // Loading from IDLE or straight out of STOP; the divisor is latched per frame.
      if (tx_pop) begin
        tx_state_q <= START;
        tx_per_q   <= period;
        tx_cnt_q   <= period - 16'd1;
        tx_shift_q <= tx_head;
        txd_q      <= 1'b0;
      end
    end
  end

  assign txd = txd_q;

  // ------------------------------------------------------------- RX FSM
  uart_state_t rx_state_q;
  logic [15:0] rx_cnt_q, rx_per_q;
  logic [2:0]  rx_bit_q;
  logic        rx_meta_q, rx_sync_q, rx_prev_q;
  logic        rx_tick, rx_fall, rx_stop_tick;

  assign rx_tick      = (rx_cnt_q == '0);
  assign rx_fall      = rx_prev_q && !rx_sync_q;
  assign rx_stop_tick = (rx_state_q == STOP) && rx_tick;
  assign rx_push      = rx_stop_tick && rx_sync_q;
  assign fe_set       = rx_stop_tick && !rx_sync_q;
  assign rxovr_set    = rx_push && rx_full && !cpu_pop;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_meta_q  <= 1'b1;
      rx_sync_q  <= 1'b1;
      rx_prev_q  <= 1'b1;
      rx_state_q <= IDLE;
      rx_cnt_q   <= '0;
      rx_per_q   <= 16'd2;
      rx_bit_q   <= '0;
      rx_shift_q <= '0;
    end else begin
      rx_meta_q <= rxd;
      rx_sync_q <= rx_meta_q;
      rx_prev_q <= rx_sync_q;
      if (!rx_tick) begin
        rx_cnt_q <= rx_cnt_q - 16'd1;
      end else begin
        unique case (rx_state_q)
          IDLE: if (rx_fall) begin
            rx_state_q <= START;
            rx_per_q   <= period;
            rx_cnt_q   <= (period >> 1) - 16'd1;
          end
          START: begin
            if (!rx_sync_q) begin
              rx_state_q <= DATA;
              rx_cnt_q   <= rx_per_q - 16'd1;
              rx_bit_q   <= '0;
            end else begin
              rx_state_q <= IDLE;
            end
          end
          DATA: begin
            rx_shift_q <= {rx_sync_q, rx_shift_q[7:1]};
            rx_cnt_q   <= rx_per_q - 16'd1;
            if (rx_bit_q == 3'd7) rx_state_q <= STOP;
            else                  rx_bit_q   <= rx_bit_q + 3'd1;
          end
          STOP:    rx_state_q <= IDLE;
          default: rx_state_q <= IDLE;
        endcase
      end
    end
  end

  // ------------------------------------------------------------ readback
  logic        rd_hit_q;
  logic [2:0]  rd_off_q;
  logic [15:0] status;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_hit_q <= 1'b0;
      rd_off_q <= '0;
    end else begin
      rd_hit_q <= (dread_addr[15:3] == ADDRBASE[15:3]);
      rd_off_q <= {dread_addr[2:1], 1'b0};
    end
  end

  always_comb begin
    status             = '0;
    status[ST_TXIDLE]  = tx_empty && (tx_state_q == IDLE);
    status[ST_TXFULL]  = tx_full;
    status[ST_RXAVAIL] = !rx_empty;
    status[ST_RXFULL]  = rx_full;
    status[ST_FE]      = fe_q;
    status[ST_RXOVR]   = rxovr_q;
    status[ST_TXOVR]   = txovr_q;
  end

  // Muxing registered state by a registered address gives the end-of-previous-cycle view.
  always_comb begin
    dread_data = '0;
    if (rd_hit_q) begin
      unique case (rd_off_q)
        UART_DATA:    dread_data = {8'h00, rx_empty ? 8'h00 : rx_head};
        UART_STATUS:  dread_data = status;
        UART_DIVISOR: dread_data = div_q;
        UART_IE:      dread_data = {13'd0, ie_q};
        default:      dread_data = '0;
      endcase
    end
  end

  assign interrupt = (ie_q[0] & status[ST_RXAVAIL]) |
                     (ie_q[1] & status[ST_TXIDLE])  |
                     (ie_q[2] & (fe_q | rxovr_q | txovr_q));

endmodule

// File: tb/tb_uart.sv
// Directed bench for the UART: register access, TX framing and back-to-back
// bursts, RX receive/overflow/framing error/glitch rejection, and mid-frame reset.
module tb_uart;

  localparam logic [15:0] A_DATA   = 16'h0010;
  localparam logic [15:0] A_STATUS = 16'h0012;
  localparam logic [15:0] A_DIV    = 16'h0014;
  localparam logic [15:0] A_IE     = 16'h0016;
  localparam int          P        = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] dread_addr, dread_data, dwrite_addr, dwrite_data;
  logic [1:0]  dwrite_en;
  logic        rxd, txd, interrupt;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  uart #(
    .ADDRBASE        (16'h0010),
    .TXDEPTH         (4),
    .RXDEPTH         (4),
    .DEFAULT_DIVISOR (16'd104)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .dread_addr  (dread_addr),
    .dread_data  (dread_data),
    .dwrite_addr (dwrite_addr),
    .dwrite_data (dwrite_data),
    .dwrite_en   (dwrite_en),
    .rxd         (rxd),
    .txd         (txd),
    .interrupt   (interrupt)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // All bus tasks start and end on a falling edge.
  task automatic wr(input logic [15:0] a, input logic [15:0] d, input logic [1:0] en);
    dwrite_addr = a;
    dwrite_data = d;
    dwrite_en   = en;
    @(posedge clk);
    @(negedge clk);
    dwrite_en = 2'b00;
  endtask

  task automatic rd(input logic [15:0] a, output logic [15:0] d);
    dread_addr = a;
    @(posedge clk);
    #1 d = dread_data;
    @(negedge clk);
  endtask

  task automatic rx_frame(input logic [7:0] b, input logic stop_bit);
    logic [9:0] f;
    f = {stop_bit, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      rxd = f[i];
      repeat (P) @(negedge clk);
    end
    rxd = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    logic [15:0] d;
    logic [3:0]  s;
    logic [9:0]  tx_exp;
    logic [9:0]  frames [5];
    logic [7:0]  burst  [6];
    logic [7:0]  rx_bytes [5];
    int          wt, lows;

    burst    = '{8'h81, 8'h12, 8'h34, 8'h56, 8'h78, 8'h9A};
    rx_bytes = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};

    reset = 1'b0; rxd = 1'b1; dwrite_en = 2'b00;
    dread_addr = 16'h0000; dwrite_addr = 16'h0000; dwrite_data = 16'h0000;
    repeat (3) @(negedge clk);
    check("reset_txd", txd, 1'b1);
    check("reset_irq", interrupt, 1'b0);
    check("reset_rdata", dread_data, 16'h0000);
    reset = 1'b1;
    @(negedge clk);
    rd(A_STATUS, d); check("reset_status", d, 16'h0001);
    rd(A_DIV, d);    check("reset_divisor", d, 16'd104);
    rd(16'h0020, d); check("outside_window", d, 16'h0000);

    // Single TX frame of 8'hA5 at P=4; each level must persist exactly P clocks.
    wr(A_DIV, 16'd4, 2'b11);
    rd(A_DIV, d); check("divisor_write", d, 16'd4);
    wr(A_DATA, 16'h00A5, 2'b01);
    dread_addr = A_STATUS;
    wt = 0;
    while (txd !== 1'b0 && wt < 20) begin
      @(negedge clk);
      wt++;
    end
    check("tx_start_latency", wt, 1);
    tx_exp = 10'b1_1010_0101_0;
    for (int j = 0; j < 10; j++) begin
      for (int m = 0; m < 4; m++) begin
        s[m] = txd;
        if (j == 9 && m == 3) check("tx_busy_last_clock", dread_data, 16'h0000);
        @(negedge clk);
      end
      check($sformatf("tx_bit%0d", j), s, {4{tx_exp[j]}});
    end
    check("tx_idle_after_frame", dread_data, 16'h0001);

    // RX a single byte, then interrupt on RXAVAIL and CPU pop.
    rx_frame(8'h3C, 1'b1);
    rd(A_STATUS, d); check("rx_status", d, 16'h0005);
    rd(A_DATA, d);   check("rx_data", d, 16'h003C);
    wr(A_IE, 16'h0001, 2'b01);
    check("irq_rxavail", interrupt, 1'b1);
    wr(A_STATUS, 16'h0001, 2'b01);
    rd(A_STATUS, d); check("rx_popped_status", d, 16'h0001);
    rd(A_DATA, d);   check("rx_empty_data", d, 16'h0000);
    check("irq_cleared", interrupt, 1'b0);

    // Five bytes into a four-entry RX FIFO.
    for (int i = 0; i < 5; i++) rx_frame(rx_bytes[i], 1'b1);
    rd(A_STATUS, d); check("rx_full_ovr_status", d, 16'h002D);
    for (int i = 0; i < 4; i++) begin
      rd(A_DATA, d);
      check($sformatf("rx_order%0d", i), d, {8'h00, rx_bytes[i]});
      wr(A_STATUS, 16'h0001, 2'b01);
    end
    rd(A_STATUS, d); check("rx_drained_status", d, 16'h0021);
    wr(A_STATUS, 16'h0020, 2'b01);
    rd(A_STATUS, d); check("rxovr_w1c", d, 16'h0001);

    // Framing error, then a one-clock glitch that must not start a frame.
    rx_frame(8'h5A, 1'b0);
    rd(A_STATUS, d); check("fe_status", d, 16'h0011);
    wr(A_IE, 16'h0004, 2'b01);
    check("irq_err", interrupt, 1'b1);
    wr(A_STATUS, 16'h0010, 2'b01);
    rd(A_STATUS, d); check("fe_w1c", d, 16'h0001);
    check("irq_err_cleared", interrupt, 1'b0);
    rxd = 1'b0;
    @(negedge clk);
    rxd = 1'b1;
    repeat (40) @(negedge clk);
    rd(A_STATUS, d); check("glitch_status", d, 16'h0001);
    rd(A_DATA, d);   check("glitch_data", d, 16'h0000);

    // Six writes while the first byte is sending: four fit, the last one overflows.
    wr(A_IE, 16'h0000, 2'b01);
    fork
      begin
        for (int i = 0; i < 6; i++) wr(A_DATA, {8'h00, burst[i]}, 2'b01);
      end
      begin
        wt = 0;
        while (txd !== 1'b0 && wt < 20) begin
          @(negedge clk);
          wt++;
        end
        check("burst_start_seen", txd, 1'b0);
        for (int c = 0; c < 200; c++) begin
          if (c % 4 == 2) frames[c / 40][(c % 40) / 4] = txd;
          @(negedge clk);
        end
      end
    join
    for (int k = 0; k < 5; k++)
      check($sformatf("burst_frame%0d", k), frames[k], {1'b1, burst[k], 1'b0});
    rd(A_STATUS, d); check("txovr_status", d, 16'h0041);
    wr(A_IE, 16'h0002, 2'b01);
    check("irq_txidle", interrupt, 1'b1);
    lows = 0;
    for (int i = 0; i < 60; i++) begin
      if (txd === 1'b0) lows++;
      @(negedge clk);
    end
    check("no_extra_frame", lows, 0);

    // Reset in the middle of a frame releases txd immediately.
    wr(A_DATA, 16'h0000, 2'b01);
    repeat (12) @(negedge clk);
    check("tx_low_before_reset", txd, 1'b0);
    #2 reset = 1'b0;
    #1 check("txd_async_reset", txd, 1'b1);
    check("irq_async_reset", interrupt, 1'b0);
    @(negedge clk);
    reset = 1'b1;
    rd(A_STATUS, d); check("status_after_reset", d, 16'h0001);
    rd(A_DIV, d);    check("divisor_after_reset", d, 16'd104);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
